// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               FSM state encoding and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Two-state controller: normal issue, or frozen waiting on data memory.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_sat_cnt.sv
// ============================================================================
// Module      : hazard_sat_cnt
// Description : Saturating up-counter with increment enable. Sticks at
//               all-ones instead of wrapping.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset (count -> 0)
//               inc    - count this cycle
//               count  - current count value [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule : hazard_sat_cnt

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and stall controller for the 5-stage pipeline. Drives
//               the write enables, bubble and flush controls of the PC and
//               pipeline registers from load-use detection, ID-stage
//               branch/jump resolution and data-memory handshake stalls.
//               All controls are combinational from registered state and
//               current inputs.
// Config      : HAZARD_PERF_EN - adds stall/flush performance counters and
//               the stall_cnt_o / flush_cnt_o ports.
// Ports       : clk_i, rst_i (async active-low)
//               id_rsaddr_i, id_rtaddr_i, id_uses_rt_i - ID source operands
//               ex_memread_i, ex_rtaddr_i              - load in EX
//               id_branch_taken_i, id_jump_i           - ID redirect
//               mem_req_i, mem_ack_i                   - data memory handshake
//               *_write_o, *_bubble_o, if_id_flush_o   - pipeline controls
//               state_o, timeout_o                     - status
//               stall_cnt_o, flush_cnt_o               - perf (optional)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rsaddr_i,
  input  logic [4:0]       id_rtaddr_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rtaddr_i,
  input  logic             id_branch_taken_i,
  input  logic             id_jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             id_ex_bubble_o,
  output logic             if_id_flush_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       state_o,
  output logic             timeout_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_flag, timeout_nxt;
  logic              freeze;
  logic              load_use;
  logic              flush;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= RUN;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      timeout_flag <= timeout_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = timeout_flag;
    freeze       = 1'b0;

    unique case (state)
      RUN: begin
        // An access acked in its first cycle never stalls.
        if (mem_req_i && !mem_ack_i) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        // mem_req_i is deliberately ignored here; the access is in flight.
        if (mem_ack_i) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          // The entry RUN cycle already counted as one frozen cycle, so
          // releasing here caps the freeze at exactly MEM_TIMEOUT cycles.
          state_nxt   = RUN;
          timeout_nxt = 1'b1;
        end else begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    load_use = ex_memread_i && (ex_rtaddr_i != REG_ZERO) &&
               ((ex_rtaddr_i == id_rsaddr_i) ||
                (id_uses_rt_i && (ex_rtaddr_i == id_rtaddr_i)));

    flush = (id_branch_taken_i || id_jump_i) && !freeze && !load_use;

    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    id_ex_write_o   = 1'b1;
    ex_mem_write_o  = 1'b1;
    id_ex_bubble_o  = 1'b0;
    if_id_flush_o   = 1'b0;
    mem_wb_bubble_o = 1'b0;

    if (freeze) begin
      // Whole front of the pipe holds; WB sees a bubble so the stalled MEM
      // instruction does not retire repeatedly.
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID; inject a bubble behind the load. A redirect in ID
      // is re-evaluated next cycle once its operand is available.
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (flush) begin
      if_id_flush_o = 1'b1;
    end
  end

  assign state_o   = state;
  assign timeout_o = timeout_flag;

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  hazard_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (!pc_write_o),
    .count (stall_cnt_o)
  );

  hazard_sat_cnt #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (if_id_flush_o),
    .count (flush_cnt_o)
  );
`endif

endmodule : hazard_ctrl

`default_nettype wire
